// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - highway/farm/pedestrian intersection phase scheduler
module intersection_scheduler #(
  parameter int MIN_GREEN_H = 8,
  parameter int GREEN_F     = 4,
  parameter int YELLOW      = 2,
  parameter int ALL_RED     = 1,
  parameter int PED_WALK    = 5,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sFarm,
  input  logic       sPed,
  output logic [1:0] H,
  output logic [1:0] F,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_H_GREEN  = 3'd0,
    S_H_YELLOW = 3'd1,
    S_ALL_RED  = 3'd2,
    S_F_GREEN  = 3'd3,
    S_F_YELLOW = 3'd4,
    S_PED_WALK = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] T_HG = CNT_W'(MIN_GREEN_H - 1);
  localparam logic [CNT_W-1:0] T_FG = CNT_W'(GREEN_F - 1);
  localparam logic [CNT_W-1:0] T_Y  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_PW = CNT_W'(PED_WALK - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             farm_pending, farm_nxt;
  logic             ped_pending, ped_nxt;
  logic             last_f, last_f_nxt;
  logic             expired;
  logic             entering;

  // State, phase timer and request latches; reset drops any pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_H_GREEN;
      timer        <= T_HG;
      farm_pending <= 1'b0;
      ped_pending  <= 1'b0;
      last_f       <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      farm_pending <= farm_nxt;
      ped_pending  <= ped_nxt;
      last_f       <= last_f_nxt;
    end
  end

  // Next-state selection, timer reload on entry, latch set/clear priority
  always_comb begin
    state_nxt = state;
    expired   = (timer == '0);
    case (state)
      S_H_GREEN:  if (expired && (farm_pending || sFarm || ped_pending || sPed))
                    state_nxt = S_H_YELLOW;
      S_H_YELLOW: if (expired) state_nxt = S_ALL_RED;
      S_ALL_RED: begin
        if (expired) begin
          if (!last_f && farm_pending) state_nxt = S_F_GREEN;
          else if (ped_pending)        state_nxt = S_PED_WALK;
          else                         state_nxt = S_H_GREEN;
        end
      end
      S_F_GREEN:  if (expired) state_nxt = S_F_YELLOW;
      S_F_YELLOW: if (expired) state_nxt = S_ALL_RED;
      S_PED_WALK: if (expired) state_nxt = S_H_GREEN;
      default:    state_nxt = S_H_GREEN;
    endcase

    entering  = (state_nxt != state);
    timer_nxt = expired ? timer : timer - CNT_W'(1);
    if (entering) begin
      case (state_nxt)
        S_H_GREEN:  timer_nxt = T_HG;
        S_H_YELLOW: timer_nxt = T_Y;
        S_ALL_RED:  timer_nxt = T_AR;
        S_F_GREEN:  timer_nxt = T_FG;
        S_F_YELLOW: timer_nxt = T_Y;
        S_PED_WALK: timer_nxt = T_PW;
        default:    timer_nxt = T_HG;
      endcase
    end

    // A fresh request beats a clear, except the clear on entering its own service phase
    farm_nxt = farm_pending;
    if (sFarm && state != S_F_GREEN && state != S_F_YELLOW) farm_nxt = 1'b1;
    if (entering && state_nxt == S_F_GREEN) farm_nxt = 1'b0;

    ped_nxt = ped_pending;
    if (sPed && state != S_PED_WALK) ped_nxt = 1'b1;
    if (entering && state_nxt == S_PED_WALK) ped_nxt = 1'b0;

    last_f_nxt = last_f;
    if (entering && state_nxt == S_F_YELLOW) last_f_nxt = 1'b1;
    if (entering && state_nxt == S_H_YELLOW) last_f_nxt = 1'b0;
  end

  // Moore output decode from the state register
  always_comb begin
    H    = 2'b00;
    F    = 2'b00;
    walk = 1'b0;
    case (state)
      S_H_GREEN:  H    = 2'b10;
      S_H_YELLOW: H    = 2'b01;
      S_F_GREEN:  F    = 2'b10;
      S_F_YELLOW: F    = 2'b01;
      S_PED_WALK: walk = 1'b1;
      default:    ;
    endcase
  end

  assign phase    = state;
  assign ped_wait = ped_pending;

endmodule
